// File: rtl/tuner_pkg.sv
// Shared types for the ring tuner lock PHY family.
package tuner_pkg;

    localparam int LOCK2_STATE_W = 3;

    // Lock PHY state encoding; the numeric values are visible on o_lock_state.
    typedef enum logic [LOCK2_STATE_W-1:0] {
        LK2_IDLE  = 3'd0,
        LK2_INIT  = 3'd1,
        LK2_DONE  = 3'd2,
        LK2_TRACK = 3'd3,
        LK2_ERROR = 3'd4
    } tuner_phy_lock2_state_e;

endpackage

// File: rtl/tuner_bb_step.sv
// One bang-bang step: classify a power sample against a deadzone around the
// target, move the heater code one step in the corrective direction and clamp
// it to [cfg_start, cfg_end]. Purely combinational.
module tuner_bb_step #(
    parameter int DAC_WIDTH = 8,
    parameter int ADC_WIDTH = 8,
    parameter int DZ_SIZE   = 4
) (
    input  logic [ADC_WIDTH-1:0] sample,
    input  logic [ADC_WIDTH-1:0] tgt,
    input  logic [DAC_WIDTH-1:0] code,
    input  logic [DAC_WIDTH:0]   step,
    input  logic [DAC_WIDTH-1:0] cfg_start,
    input  logic [DAC_WIDTH-1:0] cfg_end,
    output logic [DAC_WIDTH-1:0] next_code,
    output logic                 in_dz,
    output logic                 clamped
);

    localparam int AW1 = ADC_WIDTH + 1;
    localparam int DW2 = DAC_WIDTH + 2;
    localparam logic [AW1-1:0] ADC_MAX = {1'b0, {ADC_WIDTH{1'b1}}};
    localparam logic [AW1-1:0] DZ      = AW1'(DZ_SIZE);

    logic [AW1-1:0] tgt_ext_s;
    logic [AW1-1:0] sample_ext_s;
    logic [AW1-1:0] lo_bound_s;
    logic [AW1-1:0] hi_raw_s;
    logic [AW1-1:0] hi_bound_s;
    logic           lo_s;
    logic           hi_s;
    logic [DW2-1:0] code_ext_s;
    logic [DW2-1:0] step_ext_s;
    logic [DW2-1:0] start_ext_s;
    logic [DW2-1:0] end_ext_s;
    logic [DW2-1:0] sum_s;

    // Deadzone bounds saturate at 0 and ADC full scale so they never wrap.
    always_comb begin
        tgt_ext_s    = {1'b0, tgt};
        sample_ext_s = {1'b0, sample};
        hi_raw_s     = tgt_ext_s + DZ;
        if (tgt_ext_s >= DZ) begin
            lo_bound_s = tgt_ext_s - DZ;
        end else begin
            lo_bound_s = '0;
        end
        if (hi_raw_s > ADC_MAX) begin
            hi_bound_s = ADC_MAX;
        end else begin
            hi_bound_s = hi_raw_s;
        end
        lo_s  = (sample_ext_s < lo_bound_s);
        hi_s  = (sample_ext_s > hi_bound_s);
        in_dz = ~lo_s & ~hi_s;
    end

    // Low power raises the code, high power lowers it; a step that would
    // cross a bound (including from the bound itself) lands on it and flags.
    always_comb begin
        code_ext_s  = DW2'(code);
        step_ext_s  = DW2'(step);
        start_ext_s = DW2'(cfg_start);
        end_ext_s   = DW2'(cfg_end);
        sum_s       = code_ext_s + step_ext_s;
        next_code   = code;
        clamped     = 1'b0;
        if (lo_s) begin
            if (sum_s > end_ext_s) begin
                next_code = cfg_end;
                clamped   = 1'b1;
            end else begin
                next_code = DAC_WIDTH'(sum_s);
                clamped   = 1'b0;
            end
        end else if (hi_s) begin
            if (code_ext_s < (start_ext_s + step_ext_s)) begin
                next_code = cfg_start;
                clamped   = 1'b1;
            end else begin
                next_code = DAC_WIDTH'(code_ext_s - step_ext_s);
                clamped   = 1'b0;
            end
        end else begin
            next_code = code;
            clamped   = 1'b0;
        end
    end

endmodule

// File: rtl/tuner_lock_track_phy.sv
// Ring lock PHY: acquires lock with coarse bang-bang steps, then tracks with
// fine steps, flagging ERROR on acquisition timeout or sustained clamping.
module tuner_lock_track_phy
    import tuner_pkg::*;
#(
    parameter int DAC_WIDTH      = 8,
    parameter int ADC_WIDTH      = 8,
    parameter int DZ_SIZE        = 4,
    parameter int STRIDE_WIDTH   = 3,
    parameter int LOCK_CNT_WIDTH = 4,
    parameter int TIMEOUT_WIDTH  = 12
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [DAC_WIDTH-1:0]      i_cfg_ring_tune_start,
    input  logic [DAC_WIDTH-1:0]      i_cfg_ring_tune_end,
    input  logic [ADC_WIDTH-1:0]      i_cfg_ring_pwr_peak,
    input  logic [3:0]                i_cfg_ring_pwr_peak_ratio,
    input  logic [STRIDE_WIDTH-1:0]   i_cfg_stride_coarse,
    input  logic [STRIDE_WIDTH-1:0]   i_cfg_stride_fine,
    input  logic [LOCK_CNT_WIDTH-1:0] i_cfg_settle_cnt,
    input  logic [LOCK_CNT_WIDTH-1:0] i_cfg_sat_limit,
    input  logic [TIMEOUT_WIDTH-1:0]  i_cfg_timeout,
    input  logic                      i_pwr_detect_update,
    input  logic [ADC_WIDTH-1:0]      i_pwr_detect_val,
    output logic                      o_pwr_detect_active,
    output logic                      o_pwr_detect_refresh,
    output logic [DAC_WIDTH-1:0]      o_dig_ring_tune,
    input  logic                      i_dig_lock_trig_val,
    output logic                      o_dig_lock_trig_rdy,
    output logic                      o_dig_lock_done_val,
    input  logic                      i_dig_lock_done_rdy,
    input  logic                      i_dig_lock_track_val,
    output logic                      o_dig_lock_track_rdy,
    output logic                      o_lock_error,
    output logic [2:0]                o_lock_state
);

    localparam int LW = LOCK_CNT_WIDTH;
    localparam int TW = TIMEOUT_WIDTH;

    tuner_phy_lock2_state_e state_r, state_next_s;

    logic [DAC_WIDTH-1:0]  code_r;
    logic [ADC_WIDTH-1:0]  tgt_r;
    logic [LW-1:0]         settle_r;
    logic [LW-1:0]         sat_r;
    logic [TW-1:0]         sample_r;
    logic                  active_r, refresh_r, trig_rdy_r, done_val_r, track_rdy_r, error_r;
    logic                  active_d_s, refresh_d_s, trig_rdy_d_s, done_val_d_s, track_rdy_d_s, error_d_s;

    logic                  trig_fire_s, done_fire_s, apply_s;
    logic [STRIDE_WIDTH-1:0] stride_s;
    logic [DAC_WIDTH:0]    step_s;
    logic [ADC_WIDTH+3:0]  tgt_full_s;
    logic [ADC_WIDTH-1:0]  tgt_s;
    logic [DAC_WIDTH-1:0]  next_code_s;
    logic                  in_dz_s, clamped_s;
    logic [LW:0]           settle_inc_s, sat_inc_s;
    logic [TW:0]           sample_inc_s;
    logic                  lock_hit_s, timeout_hit_s, sat_hit_s;

    // Handshakes, active gear, step size, target and counter increments.
    always_comb begin
        trig_fire_s = i_dig_lock_trig_val & trig_rdy_r;
        done_fire_s = done_val_r & i_dig_lock_done_rdy;
        apply_s     = i_pwr_detect_update &
                      ((state_r == LK2_INIT) | ((state_r == LK2_TRACK) & i_dig_lock_track_val));
        if (state_r == LK2_TRACK) begin
            stride_s = i_cfg_stride_fine;
        end else begin
            stride_s = i_cfg_stride_coarse;
        end
        // Oversized strides give a step wider than any code range, so it always clamps.
        if (int'(stride_s) >= DAC_WIDTH) begin
            step_s = '1;
        end else begin
            step_s = (DAC_WIDTH+1)'(1) << stride_s;
        end
        tgt_full_s    = (ADC_WIDTH+4)'(i_cfg_ring_pwr_peak) * (ADC_WIDTH+4)'(i_cfg_ring_pwr_peak_ratio);
        tgt_s         = ADC_WIDTH'(tgt_full_s >> 4);
        settle_inc_s  = {1'b0, settle_r} + (LW+1)'(1);
        sat_inc_s     = {1'b0, sat_r} + (LW+1)'(1);
        sample_inc_s  = {1'b0, sample_r} + (TW+1)'(1);
        lock_hit_s    = in_dz_s & (settle_inc_s >= {1'b0, i_cfg_settle_cnt});
        timeout_hit_s = (sample_inc_s >= {1'b0, i_cfg_timeout});
        sat_hit_s     = clamped_s & (sat_inc_s >= {1'b0, i_cfg_sat_limit});
    end

    tuner_bb_step #(
        .DAC_WIDTH (DAC_WIDTH),
        .ADC_WIDTH (ADC_WIDTH),
        .DZ_SIZE   (DZ_SIZE)
    ) u_step (
        .sample    (i_pwr_detect_val),
        .tgt       (tgt_r),
        .code      (code_r),
        .step      (step_s),
        .cfg_start (i_cfg_ring_tune_start),
        .cfg_end   (i_cfg_ring_tune_end),
        .next_code (next_code_s),
        .in_dz     (in_dz_s),
        .clamped   (clamped_s)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= LK2_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a re-trigger in DONE wins over the done handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LK2_IDLE: begin
                if (trig_fire_s) state_next_s = LK2_INIT;
                else             state_next_s = LK2_IDLE;
            end
            LK2_INIT: begin
                if (apply_s && lock_hit_s)                         state_next_s = LK2_DONE;
                else if (apply_s && (timeout_hit_s || sat_hit_s))  state_next_s = LK2_ERROR;
                else                                               state_next_s = LK2_INIT;
            end
            LK2_DONE: begin
                if (trig_fire_s)      state_next_s = LK2_INIT;
                else if (done_fire_s) state_next_s = LK2_TRACK;
                else                  state_next_s = LK2_DONE;
            end
            LK2_TRACK: begin
                if (apply_s && sat_hit_s)                                   state_next_s = LK2_ERROR;
                else if (!i_dig_lock_track_val && !i_pwr_detect_update)     state_next_s = LK2_IDLE;
                else                                                        state_next_s = LK2_TRACK;
            end
            LK2_ERROR: begin
                if (trig_fire_s) state_next_s = LK2_INIT;
                else             state_next_s = LK2_ERROR;
            end
            default: state_next_s = LK2_IDLE;
        endcase
    end

    // Output decode of the upcoming state so the outputs can be registered.
    always_comb begin
        active_d_s    = (state_next_s == LK2_INIT) | (state_next_s == LK2_TRACK);
        refresh_d_s   = (state_next_s == LK2_INIT) & (state_r != LK2_INIT);
        trig_rdy_d_s  = (state_next_s == LK2_IDLE) | (state_next_s == LK2_DONE) |
                        (state_next_s == LK2_ERROR);
        done_val_d_s  = (state_next_s == LK2_DONE);
        track_rdy_d_s = (state_next_s == LK2_TRACK);
        error_d_s     = (state_next_s == LK2_ERROR);
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            active_r    <= 1'b0;
            refresh_r   <= 1'b0;
            trig_rdy_r  <= 1'b1;
            done_val_r  <= 1'b0;
            track_rdy_r <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            active_r    <= active_d_s;
            refresh_r   <= refresh_d_s;
            trig_rdy_r  <= trig_rdy_d_s;
            done_val_r  <= done_val_d_s;
            track_rdy_r <= track_rdy_d_s;
            error_r     <= error_d_s;
        end
    end

    // Heater code, target and counters: restart on INIT entry, step on applied samples.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            code_r   <= '0;
            tgt_r    <= '0;
            settle_r <= '0;
            sat_r    <= '0;
            sample_r <= '0;
        end else if ((state_next_s == LK2_INIT) && (state_r != LK2_INIT)) begin
            code_r   <= i_cfg_ring_tune_start;
            tgt_r    <= tgt_s;
            settle_r <= '0;
            sat_r    <= '0;
            sample_r <= '0;
        end else if (apply_s) begin
            code_r <= next_code_s;
            if (clamped_s) begin
                sat_r <= sat_inc_s[LW] ? '1 : sat_inc_s[LW-1:0];
            end else begin
                sat_r <= '0;
            end
            if (state_r == LK2_INIT) begin
                if (in_dz_s) begin
                    settle_r <= settle_inc_s[LW] ? '1 : settle_inc_s[LW-1:0];
                end else begin
                    settle_r <= '0;
                end
                sample_r <= sample_inc_s[TW] ? '1 : sample_inc_s[TW-1:0];
            end else begin
                settle_r <= settle_r;
                sample_r <= sample_r;
            end
        end else if ((state_r == LK2_DONE) && (state_next_s == LK2_TRACK)) begin
            sat_r <= '0;
        end else begin
            code_r <= code_r;
        end
    end

    assign o_pwr_detect_active  = active_r;
    assign o_pwr_detect_refresh = refresh_r;
    assign o_dig_ring_tune      = code_r;
    assign o_dig_lock_trig_rdy  = trig_rdy_r;
    assign o_dig_lock_done_val  = done_val_r;
    assign o_dig_lock_track_rdy = track_rdy_r;
    assign o_lock_error         = error_r;
    assign o_lock_state         = state_r;

endmodule
